// File: rtl/write_queued_pkg.sv
// rtl/write_queued_pkg.sv - shared register-file types, special register indices and store-queue entry
package write_queued_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NR_DEF    = 32;
    localparam int PC_IDX    = NR_DEF - 1;
    localparam int FLAGS_IDX = NR_DEF - 2;

    typedef logic [XLEN_DEF-1:0] regval_t;
    typedef regval_t [NR_DEF-1:0] regfile_t;

    localparam regfile_t ZERO_REG_FILE = '0;

    typedef struct packed {
        regval_t address;
        regval_t data;
    } sq_entry_t;

endpackage

// File: rtl/write_queued_store_queue.sv
// rtl/write_queued_store_queue.sv - circular store FIFO with same-edge push/pop at any occupancy
module store_queue
    import write_queued_pkg::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    push,
    input  sq_entry_t               push_entry,
    input  logic                    pop,
    output sq_entry_t               head_entry,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(SQ_DEPTH):0] count
);

    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sq_entry_t        entries [SQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(SQ_DEPTH));
    assign do_pop     = pop && !empty;
    // A pop in the same edge frees the slot, so a full queue still accepts.
    assign do_push    = push && (!full || do_pop);
    assign head_entry = entries[head];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (do_push) begin
            entries[tail] <= push_entry;
        end
    end

endmodule

// File: rtl/write_queued.sv
// rtl/write_queued.sv - writeback stage with register-file update, flags merge and queued memory stores
module write_queued
    import write_queued_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NR       = 32,
    parameter int SQ_DEPTH = 4,
    parameter int FLAGS_W  = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        is_valid,
    output logic                        hold,
    input  logic [$clog2(NR)-1:0]       target_register,
    input  logic [$clog2(NR)-1:0]       address_register,
    input  logic [XLEN-1:0]             target_value,
    input  logic [XLEN-1:0]             upper_value,
    input  logic [XLEN-1:0]             adjustment_value,
    input  logic [XLEN-1:0]             pc,
    input  logic [XLEN-1:0]             next_pc,
    input  logic                        has_upper_value,
    input  logic                        is_writing_memory,
    input  logic                        has_flushed,
    input  logic [FLAGS_W-1:0]          flags,
    input  logic [NR*XLEN-1:0]          input_registers,
    output logic [NR*XLEN-1:0]          output_registers,
    output logic                        mem_address_enable,
    output logic [XLEN-1:0]             mem_address,
    output logic [XLEN-1:0]             mem_data,
    input  logic                        mem_data_valid,
    output logic                        flushed_out,
    output logic                        fb_is_valid,
    output logic                        fb_has_upper_value,
    output logic [$clog2(NR)-1:0]       fb_index,
    output logic [XLEN-1:0]             fb_value,
    output logic [XLEN-1:0]             fb_upper_value,
    output logic [$clog2(SQ_DEPTH):0]   sq_count
);

    localparam int IDX_W = $clog2(NR);
    localparam logic [IDX_W-1:0] PC_SEL = IDX_W'(PC_IDX);

    regfile_t         in_regs;
    regfile_t         next_regs;
    regfile_t         out_regs;
    logic [IDX_W-1:0] upper_index;
    regval_t          store_base;
    regval_t          store_address;
    regval_t          pc_next_value;
    sq_entry_t        push_entry;
    sq_entry_t        head_entry;
    logic             sq_full;
    logic             sq_empty;
    logic             sq_push;
    logic             sq_pop;

    assign in_regs          = input_registers;
    assign output_registers = out_regs;

    // A store's upper value lands in its own target; otherwise it goes to the pair register.
    assign upper_index = is_writing_memory ? target_register : target_register + IDX_W'(1);

    always_comb begin
        next_regs            = in_regs;
        next_regs[FLAGS_IDX] = {in_regs[FLAGS_IDX][XLEN-1], flags,
                                in_regs[FLAGS_IDX][XLEN-2-FLAGS_W:0]};
        if (!is_writing_memory) begin
            next_regs[target_register] = target_value;
        end
        if (has_upper_value) begin
            next_regs[upper_index] = upper_value;
        end
        next_regs[0] = '0;
    end

    assign store_base    = (address_register == PC_SEL) ? pc : next_regs[address_register];
    assign store_address = store_base + adjustment_value;

    always_comb begin
        pc_next_value = next_pc;
        if (is_valid && !is_writing_memory && target_register == PC_SEL) begin
            pc_next_value = target_value;
        end else if (is_valid && is_writing_memory && has_upper_value && target_register == PC_SEL) begin
            pc_next_value = upper_value;
        end
    end

    // Reset gates the handshake so nothing escapes while the queue is being cleared.
    assign mem_address_enable = reset_n && !sq_empty;
    assign sq_pop             = mem_address_enable && mem_data_valid;
    assign hold               = reset_n && is_valid && is_writing_memory && sq_full && !sq_pop;
    assign sq_push            = reset_n && is_valid && is_writing_memory && !hold;
    assign push_entry         = '{address: store_address, data: target_value};
    assign mem_address        = head_entry.address;
    assign mem_data           = head_entry.data;

    store_queue #(
        .SQ_DEPTH (SQ_DEPTH)
    ) u_store_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (sq_push),
        .push_entry (push_entry),
        .pop        (sq_pop),
        .head_entry (head_entry),
        .full       (sq_full),
        .empty      (sq_empty),
        .count      (sq_count)
    );

    always_comb begin
        fb_index       = target_register;
        fb_upper_value = upper_value;
        if (is_writing_memory && has_upper_value) begin
            fb_value           = upper_value;
            fb_is_valid        = is_valid;
            fb_has_upper_value = 1'b0;
        end else begin
            fb_value           = target_value;
            fb_is_valid        = is_valid && !is_writing_memory;
            fb_has_upper_value = has_upper_value;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_regs    <= ZERO_REG_FILE;
            flushed_out <= 1'b0;
        end else begin
            if (is_valid && !hold) begin
                out_regs <= next_regs;
            end
            out_regs[PC_IDX] <= pc_next_value;
            flushed_out      <= is_valid && has_flushed;
        end
    end

endmodule

// File: tb/tb_write_queued.sv
// tb/tb_write_queued.sv - directed self-checking bench for write_queued
module tb_write_queued;

    logic          clock;
    logic          reset_n;
    logic          is_valid;
    logic          hold;
    logic [4:0]    target_register;
    logic [4:0]    address_register;
    logic [31:0]   target_value;
    logic [31:0]   upper_value;
    logic [31:0]   adjustment_value;
    logic [31:0]   pc;
    logic [31:0]   next_pc;
    logic          has_upper_value;
    logic          is_writing_memory;
    logic          has_flushed;
    logic [3:0]    flags;
    logic [1023:0] input_registers;
    logic [1023:0] output_registers;
    logic          mem_address_enable;
    logic [31:0]   mem_address;
    logic [31:0]   mem_data;
    logic          mem_data_valid;
    logic          flushed_out;
    logic          fb_is_valid;
    logic          fb_has_upper_value;
    logic [4:0]    fb_index;
    logic [31:0]   fb_value;
    logic [31:0]   fb_upper_value;
    logic [2:0]    sq_count;

    int checks = 0;
    int errors = 0;

    write_queued dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .is_valid           (is_valid),
        .hold               (hold),
        .target_register    (target_register),
        .address_register   (address_register),
        .target_value       (target_value),
        .upper_value        (upper_value),
        .adjustment_value   (adjustment_value),
        .pc                 (pc),
        .next_pc            (next_pc),
        .has_upper_value    (has_upper_value),
        .is_writing_memory  (is_writing_memory),
        .has_flushed        (has_flushed),
        .flags              (flags),
        .input_registers    (input_registers),
        .output_registers   (output_registers),
        .mem_address_enable (mem_address_enable),
        .mem_address        (mem_address),
        .mem_data           (mem_data),
        .mem_data_valid     (mem_data_valid),
        .flushed_out        (flushed_out),
        .fb_is_valid        (fb_is_valid),
        .fb_has_upper_value (fb_has_upper_value),
        .fb_index           (fb_index),
        .fb_value           (fb_value),
        .fb_upper_value     (fb_upper_value),
        .sq_count           (sq_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] reg_at(input int i);
        return output_registers[i*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        is_valid          = 1'b0;
        target_register   = '0;
        address_register  = '0;
        target_value      = '0;
        upper_value       = '0;
        adjustment_value  = '0;
        pc                = 32'h0000_0080;
        next_pc           = 32'h0000_0040;
        has_upper_value   = 1'b0;
        is_writing_memory = 1'b0;
        has_flushed       = 1'b0;
        flags             = '0;
        mem_data_valid    = 1'b0;
    endtask

    task automatic drive_store(input logic [4:0] areg, input logic [31:0] adj, input logic [31:0] data);
        is_valid          = 1'b1;
        is_writing_memory = 1'b1;
        has_upper_value   = 1'b0;
        target_register   = 5'd9;
        address_register  = areg;
        adjustment_value  = adj;
        target_value      = data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_idle();
        input_registers = '0;
        input_registers[0*32 +: 32]  = 32'h0000_DEAD;
        input_registers[2*32 +: 32]  = 32'h0000_0100;
        input_registers[3*32 +: 32]  = 32'h0000_0033;
        input_registers[30*32 +: 32] = 32'hFFFF_FFFF;
        step();
        step();
        checks++; if (output_registers !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", output_registers[63:0]); end
        checks++; if (sq_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sq_count); end
        checks++; if (mem_address_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", mem_address_enable); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", hold); end
        checks++; if (flushed_out !== 1'b0) begin errors++; $display("FAIL reset_flushed got %b want 0", flushed_out); end
        reset_n = 1'b1;
        step();
        checks++; if (reg_at(31) !== 32'h40) begin errors++; $display("FAIL idle_pc got %h want 00000040", reg_at(31)); end
        checks++; if (reg_at(2) !== 32'h0) begin errors++; $display("FAIL idle_r2_held got %h want 0", reg_at(2)); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            drive_store(5'd2, 32'h4, 32'hA + k);
            #1;
            checks++; if (hold !== 1'b0) begin errors++; $display("FAIL fill_hold_%0d got %b want 0", k, hold); end
            step();
        end
        checks++; if (sq_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", sq_count); end
        checks++; if (mem_address_enable !== 1'b1) begin errors++; $display("FAIL fill_enable got %b want 1", mem_address_enable); end
        checks++; if (mem_address !== 32'h104 || mem_data !== 32'hA) begin errors++; $display("FAIL fill_head got %h/%h want 00000104/0000000a", mem_address, mem_data); end
        checks++; if (reg_at(30) !== 32'h87FF_FFFF) begin errors++; $display("FAIL fill_flags got %h want 87ffffff", reg_at(30)); end
        checks++; if (reg_at(0) !== 32'h0) begin errors++; $display("FAIL fill_r0 got %h want 0", reg_at(0)); end
        checks++; if (reg_at(2) !== 32'h100) begin errors++; $display("FAIL fill_r2 got %h want 00000100", reg_at(2)); end
        drive_store(5'd2, 32'h4, 32'hE);
        flags = 4'hF;
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL fifth_hold got %b want 1", hold); end
        step();
        checks++; if (sq_count !== 3'd4) begin errors++; $display("FAIL fifth_count got %0d want 4", sq_count); end
        checks++; if (reg_at(30) !== 32'h87FF_FFFF) begin errors++; $display("FAIL held_flags got %h want 87ffffff", reg_at(30)); end
        flags = 4'h0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] expect_data;
        drive_store(5'd2, 32'h4, 32'hE);
        mem_data_valid = 1'b1;
        #1;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL pushpop_hold got %b want 0", hold); end
        checks++; if (mem_address !== 32'h104 || mem_data !== 32'hA) begin errors++; $display("FAIL pushpop_head got %h/%h want 00000104/0000000a", mem_address, mem_data); end
        step();
        checks++; if (sq_count !== 3'd4) begin errors++; $display("FAIL pushpop_count got %0d want 4", sq_count); end
        checks++; if (mem_data !== 32'hB) begin errors++; $display("FAIL pushpop_next got %h want 0000000b", mem_data); end
        set_idle();
        mem_data_valid = 1'b1;
        expect_data = 32'hB;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (mem_data !== expect_data || mem_address !== 32'h104) begin errors++; $display("FAIL drain_%0d got %h/%h want 00000104/%h", k, mem_address, mem_data, expect_data); end
            step();
            expect_data = expect_data + 32'h1;
        end
        checks++; if (sq_count !== 3'd0 || mem_address_enable !== 1'b0) begin errors++; $display("FAIL drain_empty got %0d/%b want 0/0", sq_count, mem_address_enable); end
        mem_data_valid = 1'b0;
    endtask

    task automatic test_upper();
        set_idle();
        is_valid        = 1'b1;
        target_register = 5'd5;
        target_value    = 32'h1234;
        has_upper_value = 1'b1;
        upper_value     = 32'h55;
        flags           = 4'b1010;
        #1;
        checks++; if (fb_is_valid !== 1'b1 || fb_has_upper_value !== 1'b1) begin errors++; $display("FAIL upper_fb_flags got %b%b want 11", fb_is_valid, fb_has_upper_value); end
        checks++; if (fb_value !== 32'h1234 || fb_upper_value !== 32'h55 || fb_index !== 5'd5) begin errors++; $display("FAIL upper_fb_vals got %h/%h/%0d want 00001234/00000055/5", fb_value, fb_upper_value, fb_index); end
        step();
        checks++; if (reg_at(5) !== 32'h1234 || reg_at(6) !== 32'h55) begin errors++; $display("FAIL upper_regs got %h/%h want 00001234/00000055", reg_at(5), reg_at(6)); end
        checks++; if (reg_at(30) !== 32'hD7FF_FFFF) begin errors++; $display("FAIL upper_flags got %h want d7ffffff", reg_at(30)); end
        checks++; if (reg_at(31) !== 32'h40) begin errors++; $display("FAIL upper_pc got %h want 00000040", reg_at(31)); end
        target_register = 5'd31;
        target_value    = 32'h777;
        upper_value     = 32'h66;
        step();
        checks++; if (reg_at(31) !== 32'h777 || reg_at(0) !== 32'h0) begin errors++; $display("FAIL pc_target got %h/%h want 00000777/0", reg_at(31), reg_at(0)); end
    endtask

    task automatic test_store_upper();
        set_idle();
        drive_store(5'd3, 32'h10, 32'h99);
        target_register = 5'd3;
        has_upper_value = 1'b1;
        upper_value     = 32'h200;
        #1;
        checks++; if (fb_value !== 32'h200 || fb_is_valid !== 1'b1 || fb_has_upper_value !== 1'b0) begin errors++; $display("FAIL store_fb got %h/%b/%b want 00000200/1/0", fb_value, fb_is_valid, fb_has_upper_value); end
        step();
        checks++; if (reg_at(3) !== 32'h200) begin errors++; $display("FAIL store_r3 got %h want 00000200", reg_at(3)); end
        checks++; if (mem_address !== 32'h210 || mem_data !== 32'h99 || sq_count !== 3'd1) begin errors++; $display("FAIL store_fwd got %h/%h/%0d want 00000210/00000099/1", mem_address, mem_data, sq_count); end
        drive_store(5'd31, 32'h8, 32'h77);
        target_register = 5'd31;
        has_upper_value = 1'b1;
        upper_value     = 32'h300;
        step();
        checks++; if (reg_at(31) !== 32'h300 || sq_count !== 3'd2) begin errors++; $display("FAIL store_pc got %h/%0d want 00000300/2", reg_at(31), sq_count); end
        set_idle();
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        checks++; if (mem_address !== 32'h88 || mem_data !== 32'h77 || sq_count !== 3'd1) begin errors++; $display("FAIL store_pcbase got %h/%h/%0d want 00000088/00000077/1", mem_address, mem_data, sq_count); end
    endtask

    task automatic test_flush();
        set_idle();
        is_valid        = 1'b1;
        has_flushed     = 1'b1;
        target_register = 5'd7;
        target_value    = 32'h1;
        step();
        checks++; if (flushed_out !== 1'b1 || sq_count !== 3'd1) begin errors++; $display("FAIL flush_set got %b/%0d want 1/1", flushed_out, sq_count); end
        set_idle();
        has_flushed = 1'b1;
        step();
        checks++; if (flushed_out !== 1'b0) begin errors++; $display("FAIL flush_invalid got %b want 0", flushed_out); end
    endtask

    task automatic test_reset_inflight();
        set_idle();
        for (int k = 0; k < 2; k++) begin
            drive_store(5'd2, 32'h20, 32'h50 + k);
            step();
        end
        checks++; if (sq_count !== 3'd3) begin errors++; $display("FAIL inflight_count got %0d want 3", sq_count); end
        drive_store(5'd2, 32'h20, 32'h60);
        mem_data_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++; if (hold !== 1'b0 || mem_address_enable !== 1'b0) begin errors++; $display("FAIL inreset_comb got %b/%b want 0/0", hold, mem_address_enable); end
        step();
        checks++; if (sq_count !== 3'd0 || mem_address_enable !== 1'b0) begin errors++; $display("FAIL inflight_reset got %0d/%b want 0/0", sq_count, mem_address_enable); end
        checks++; if (output_registers !== '0) begin errors++; $display("FAIL inflight_regs got %h want 0", output_registers[127:0]); end
        set_idle();
        reset_n = 1'b1;
        step();
        checks++; if (sq_count !== 3'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", sq_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_upper();
        test_store_upper();
        test_flush();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
